// File: rtl/pwm_multichannel.sv
// pwm_multichannel: multi-channel PWM generator, one shared period counter, double-buffered duties
//   clock        system clock, rising edge
//   reset        asynchronous active-low reset
//   wr_en        duty write strobe
//   wr_chan      target channel of the write (out-of-range channels are ignored)
//   wr_duty      duty code; high time = duty*STEP counter steps
//   ch_enable    per-channel enable, sampled at period boundaries
//   outPWM       registered PWM outputs, INVERT selects active-low channels
//   period_start one-clock pulse in the clock where the counter reads 0
module pwm_multichannel #(
   parameter int CHANNELS = 4,
   parameter int DUTY_W = 8,
   parameter int PERIOD = 25000,
   parameter int STEP = 100,
   parameter int PRESCALE = 1,
   parameter logic [CHANNELS-1:0] INVERT = '0
) (
   input  logic clock,
   input  logic reset,
   input  logic wr_en,
   input  logic [(CHANNELS > 1 ? $clog2(CHANNELS) : 1)-1:0] wr_chan,
   input  logic [DUTY_W-1:0] wr_duty,
   input  logic [CHANNELS-1:0] ch_enable,
   output logic [CHANNELS-1:0] outPWM,
   output logic period_start
);
   localparam int CHAN_W = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
   localparam int CNT_W = $clog2(PERIOD);
   localparam int PRE_W = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
   localparam int THR_W = DUTY_W + $clog2(STEP + 1);
   localparam int CMP_W = THR_W > CNT_W ? THR_W : CNT_W;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);

   logic [PRE_W-1:0] pre;
   logic [CNT_W-1:0] cnt;
   logic tick, boundary;
   logic [CHANNELS-1:0] hit, enAct, lvl;
   logic [CHANNELS-1:0][DUTY_W-1:0] shadow, active;

   // with PRESCALE=1 pre is pinned at 0, so tick is permanently high
   assign tick = pre == PRE_LAST;
   assign boundary = tick && cnt == CNT_LAST;

   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         pre <= '0;
         cnt <= '0;
      end else begin
         pre <= tick ? '0 : pre + 1'b1;
         if (tick) cnt <= boundary ? '0 : cnt + 1'b1;
      end

   // threshold is kept at full width so duty*STEP >= PERIOD stays high across the wrap
   always_comb begin
      hit = '0;
      lvl = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         hit[c] = wr_en && wr_chan == CHAN_W'(c);
         lvl[c] = enAct[c] && (CMP_W'(cnt) < CMP_W'(THR_W'(active[c]) * THR_W'(STEP)));
      end
   end

   // a write landing in the boundary cycle bypasses the shadow straight into active
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         shadow <= '0;
         active <= '0;
         enAct <= '0;
         outPWM <= INVERT;
         period_start <= 1'b0;
      end else begin
         for (int c = 0; c < CHANNELS; c++) begin
            if (hit[c]) shadow[c] <= wr_duty;
            if (boundary) active[c] <= hit[c] ? wr_duty : shadow[c];
         end
         if (boundary) enAct <= ch_enable;
         outPWM <= lvl ^ INVERT;
         period_start <= boundary;
      end
endmodule
